accum_hex_reader: RTL and testbench
===================================

Name: accum_hex_reader

Overview:
- Reads the binary running total produced by the accumulator datapath (the value normally shown on LEDR) and drives it to the DE-series HEX displays as decimal.
- Conversion is sequential shift-add-3 (double-dabble), one bit per clock, started by a load strobe. The last converted value is held on the displays between conversions.
- Sits beside the accumulator in top-level designs: the accumulator writes the total, this block reads it and presents it.

Parameters:
- W, 10, width of the binary input value.
- DIGITS, 4, number of BCD digits and HEX displays driven.
- BLANK_LZ, 1, 1 = blank leading zeros, 0 = show all digits.

Ports:
- Clock  input  1  system clock (CLOCK_50 at top level)
- Reset  input  1  asynchronous, active-high reset
- value  input  W  binary value to display, sampled on start
- start  input  1  single-cycle request to convert value
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the displays update
- hex  output  7*DIGITS  segment bus, digit k at [7k+6:7k], HEX0 = digit 0
  - Segments are active-low; bit 0 = a … bit 6 = g.

Behaviour:
- Reset, asynchronous and active-high:
  - state = IDLE, busy = 0, done = 0, shift and BCD registers = 0.
  - hex = all ones (every display blank).
  - Reset asserted mid-conversion aborts the conversion; hex goes blank, not to the old value.
- State IDLE:
  - If start = 1 at edge N: capture value into the shift register, clear the BCD register, load bit counter = W, go to CONVERT.
  - busy = 1 from after edge N.
- State CONVERT: one iteration per edge.
  - Each BCD nibble >= 5 gets +3.
  - Then shift {bcd, shift} left 1 and decrement the counter.
  - After the W-th iteration (edge N+W) go to LATCH.
- State LATCH, edge N+W+1:
  - Register hex from the BCD result.
  - done = 1 for exactly that cycle, busy = 0, return to IDLE.
  - Total latency from start edge to hex update: W+1 clocks (11 for W=10).
- start while busy: ignored, with no queuing and no restart. start in the same cycle done is high is accepted, since state is IDLE.
- value changes after the start edge have no effect on the result.
- Digit encoding:
  - Standard active-low 0-9; "0" = 1000000, "1" = 1111001.
  - Blank = 1111111; dash = 0111111 (only g lit).
- Leading-zero blanking (BLANK_LZ=1):
  - Digits above the most significant nonzero digit are blank.
  - value 0 displays "0" on HEX0, all others blank.
- Overflow: if the BCD result does not fit in DIGITS digits (a carry into nibble DIGITS), every digit shows dash.
  - BCD register is DIGITS+1 nibbles internally for this detection.
- Width rule: internal BCD register is 4*(DIGITS+1) bits; no truncation before the overflow check.

Test Plan:
- Reset, then value=1023, start pulse -> busy high for cycles 1-10, done at cycle 11, hex digits 3..0 = "1","0","2","3".
- value=7, BLANK_LZ=1 -> HEX3..HEX1 = 1111111, HEX0 = "7" (1111000); with BLANK_LZ=0 -> "0","0","0","7".
- value=0 -> HEX0 = 1000000, others blank, done pulses once only.
- Convert 512, then assert start again at cycles 3 and 6 with value=99 -> ignored, result "512"; start on the done cycle with 99 -> second done 11 cycles later, shows "99".
- W=14, DIGITS=4, value=12345 -> all four digits 0111111; value=9999 -> "9999".
- Reset asserted at cycle 5 of a 1023 conversion -> hex all 1111111, busy=0, no done pulse; next start converts correctly.

Source files
------------

// File: rtl/accum_hex_reader_if.sv
// accum_hex_reader_if
//   Bundle between a requester (master) and the binary-to-HEX reader (slave).
//   value     : binary value to convert, sampled when start is accepted
//   start     : single-cycle convert request (master -> slave)
//   busy      : conversion in progress (slave -> master)
//   done      : one-cycle pulse when hex updates (slave -> master)
//   hex       : 7*DIGITS active-low segments, digit k at [7k+6:7k]
//   dbg_state : reader FSM state (0 = IDLE, 1 = CONVERT, 2 = LATCH)
//
// Handshake: start is a request strobe; it is taken only when the reader is
// idle (busy = 0). A request made while busy is dropped, not queued. Each
// accepted request produces exactly one done pulse, unless reset intervenes.
interface accum_hex_reader_if #(
   parameter int W      = 10,
   parameter int DIGITS = 4
);
   logic [W-1:0]          value;
   logic                  start;
   logic                  busy;
   logic                  done;
   logic [7*DIGITS-1:0]   hex;
   logic [1:0]            dbg_state;

   modport master (
      output value, start,
      input  busy, done, hex, dbg_state
   );

   modport slave (
      input  value, start,
      output busy, done, hex, dbg_state
   );
endinterface

// File: rtl/accum_hex_reader.sv
// accum_hex_reader
//   Converts the accumulator's binary total into decimal on the HEX displays
//   using sequential shift-add-3 (one bit per clock). The last result stays
//   on the displays between conversions.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset (blanks all displays)
//   bus : accum_hex_reader_if slave (value/start in, busy/done/hex out)
module accum_hex_reader #(
   parameter int W        = 10,
   parameter int DIGITS   = 4,
   parameter int BLANK_LZ = 1
) (
   input  logic                clk,
   input  logic                rst,
   accum_hex_reader_if.slave   bus
);
   // One spare nibble above the displayed digits catches overflow.
   localparam int BW = 4 * (DIGITS + 1);
   localparam int CW = $clog2(W + 1);

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      LATCH   = 2'd2
   } state_t;

   state_t                state;
   logic [W-1:0]          sh;
   logic [BW-1:0]         bcd;
   logic [CW-1:0]         cnt;
   logic                  busy_r;
   logic                  done_r;
   logic [7*DIGITS-1:0]   hex_r;

   logic [BW-1:0]         bcd_adj;
   logic [7*DIGITS-1:0]   hex_next;
   logic                  overflow;
   logic                  lead;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   // Add-3 correction on every nibble before the shift.
   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i <= DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   // Segment image of the finished BCD result. Scanning from the top digit,
   // 'lead' stays set while only zeros have been seen; digit 0 is never blank.
   always_comb begin
      hex_next = '1;
      overflow = (bcd[BW-1 -: 4] != 4'd0);
      lead     = (BLANK_LZ != 0);
      for (int k = DIGITS - 1; k >= 0; k--) begin
         if (overflow) begin
            hex_next[7*k +: 7] = SEG_DASH;
         end else if (lead && (bcd[4*k +: 4] == 4'd0) && (k != 0)) begin
            hex_next[7*k +: 7] = SEG_BLANK;
         end else begin
            hex_next[7*k +: 7] = seg7(bcd[4*k +: 4]);
            lead = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sh     <= '0;
         bcd    <= '0;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         hex_r  <= '1;
      end else begin
         done_r <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  sh     <= bus.value;
                  bcd    <= '0;
                  cnt    <= CW'(W);
                  busy_r <= 1'b1;
                  state  <= CONVERT;
               end
            end
            CONVERT: begin
               bcd <= {bcd_adj[BW-2:0], sh[W-1]};
               sh  <= sh << 1;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state <= LATCH;
               end
            end
            LATCH: begin
               hex_r  <= hex_next;
               done_r <= 1'b1;
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.hex       = hex_r;
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_accum_hex_reader.sv
// tb_accum_hex_reader
//   Directed bench for accum_hex_reader. Three instances share clk/rst/start:
//   a (W=10, blanking), b (W=10, no blanking), c (W=14, blanking).
module tb_accum_hex_reader;
   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] DS = 7'b0111111;

   localparam logic [27:0] EXP_1023 = {S1, S0, S2, S3};

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [13:0] value;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   accum_hex_reader_if #(.W(10), .DIGITS(4)) ifa ();
   accum_hex_reader_if #(.W(10), .DIGITS(4)) ifb ();
   accum_hex_reader_if #(.W(14), .DIGITS(4)) ifc ();

   assign ifa.start = start;
   assign ifa.value = value[9:0];
   assign ifb.start = start;
   assign ifb.value = value[9:0];
   assign ifc.start = start;
   assign ifc.value = value;

   accum_hex_reader #(.W(10), .DIGITS(4), .BLANK_LZ(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   accum_hex_reader #(.W(10), .DIGITS(4), .BLANK_LZ(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
   accum_hex_reader #(.W(14), .DIGITS(4), .BLANK_LZ(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

   // Returns #1 after the edge that accepts the request (edge N).
   task automatic start_edge(input logic [13:0] v);
      @(posedge clk); #1;
      value = v;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_a(input int budget, output int n);
      n = 0;
      while (ifa.done !== 1'b1 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic wait_c(input int budget, output int n);
      n = 0;
      while (ifc.done !== 1'b1 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (ifa.hex !== {28{1'b1}}) begin bad++; $display("FAIL reset_hex_a: got %h want %h", ifa.hex, {28{1'b1}}); end
      total++; if (ifc.hex !== {28{1'b1}}) begin bad++; $display("FAIL reset_hex_c: got %h want %h", ifc.hex, {28{1'b1}}); end
      total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", ifa.busy); end
      total++; if (ifa.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", ifa.done); end
      total++; if (ifa.dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", ifa.dbg_state); end
      rst = 1'b0;
   endtask

   task automatic test_1023;
      start_edge(14'd1023);
      total++; if (ifa.busy !== 1'b1 || ifa.done !== 1'b0) begin bad++; $display("FAIL lat_c0: busy=%b done=%b want 1/0", ifa.busy, ifa.done); end
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk); #1;
         if (k <= 10) begin
            total++; if (ifa.busy !== 1'b1 || ifa.done !== 1'b0) begin bad++; $display("FAIL lat_c%0d: busy=%b done=%b want 1/0", k, ifa.busy, ifa.done); end
         end
         if (k == 5) begin
            total++; if (ifa.dbg_state !== 2'd1) begin bad++; $display("FAIL conv_state: got %0d want 1", ifa.dbg_state); end
         end
      end
      total++; if (ifa.done !== 1'b1 || ifa.busy !== 1'b0) begin bad++; $display("FAIL lat_c11: busy=%b done=%b want 0/1", ifa.busy, ifa.done); end
      total++; if (ifa.hex !== EXP_1023) begin bad++; $display("FAIL hex_1023_a: got %h want %h", ifa.hex, EXP_1023); end
      total++; if (ifb.hex !== EXP_1023) begin bad++; $display("FAIL hex_1023_b: got %h want %h", ifb.hex, EXP_1023); end
      @(posedge clk); #1;
      total++; if (ifa.done !== 1'b0) begin bad++; $display("FAIL done_width: got %b want 0", ifa.done); end
   endtask

   task automatic test_blank;
      int n;
      start_edge(14'd7);
      wait_a(20, n);
      total++; if (n !== 11) begin bad++; $display("FAIL lat_7: got %0d want 11", n); end
      total++; if (ifa.hex !== {BL, BL, BL, S7}) begin bad++; $display("FAIL hex_7_lz: got %h want %h", ifa.hex, {BL, BL, BL, S7}); end
      total++; if (ifb.hex !== {S0, S0, S0, S7}) begin bad++; $display("FAIL hex_7_nolz: got %h want %h", ifb.hex, {S0, S0, S0, S7}); end
   endtask

   task automatic test_zero;
      int pulses;
      start_edge(14'd0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (ifa.done === 1'b1) pulses++;
      end
      total++; if (pulses !== 1) begin bad++; $display("FAIL zero_pulses: got %0d want 1", pulses); end
      total++; if (ifa.hex !== {BL, BL, BL, S0}) begin bad++; $display("FAIL hex_0: got %h want %h", ifa.hex, {BL, BL, BL, S0}); end
   endtask

   task automatic test_back_to_back;
      int n;
      start_edge(14'd512);
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk); #1;
         if (k == 2 || k == 5) begin
            value = 14'd99;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      total++; if (ifa.done !== 1'b1) begin bad++; $display("FAIL b2b_done1: got %b want 1", ifa.done); end
      total++; if (ifa.hex !== {BL, S5, S1, S2}) begin bad++; $display("FAIL hex_512: got %h want %h", ifa.hex, {BL, S5, S1, S2}); end
      // Request on the done cycle must be taken.
      value = 14'd99;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (ifa.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", ifa.busy); end
      wait_a(20, n);
      total++; if (n !== 11) begin bad++; $display("FAIL b2b_lat: got %0d want 11", n); end
      total++; if (ifa.hex !== {BL, BL, S9, S9}) begin bad++; $display("FAIL hex_99: got %h want %h", ifa.hex, {BL, BL, S9, S9}); end
   endtask

   task automatic test_overflow;
      int n;
      repeat (16) @(posedge clk);
      start_edge(14'd12345);
      wait_c(30, n);
      total++; if (n !== 15) begin bad++; $display("FAIL lat_w14: got %0d want 15", n); end
      total++; if (ifc.hex !== {DS, DS, DS, DS}) begin bad++; $display("FAIL hex_12345: got %h want %h", ifc.hex, {DS, DS, DS, DS}); end
      start_edge(14'd9999);
      wait_c(30, n);
      total++; if (ifc.hex !== {S9, S9, S9, S9}) begin bad++; $display("FAIL hex_9999: got %h want %h", ifc.hex, {S9, S9, S9, S9}); end
   endtask

   task automatic test_reset_abort;
      int n;
      int pulses;
      repeat (16) @(posedge clk);
      start_edge(14'd1023);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      total++; if (ifa.hex !== {28{1'b1}}) begin bad++; $display("FAIL abort_hex: got %h want %h", ifa.hex, {28{1'b1}}); end
      total++; if (ifa.busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", ifa.busy); end
      total++; if (ifa.dbg_state !== 2'd0) begin bad++; $display("FAIL abort_state: got %0d want 0", ifa.dbg_state); end
      @(posedge clk); #1;
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (ifa.done === 1'b1) pulses++;
      end
      total++; if (pulses !== 0) begin bad++; $display("FAIL abort_done: got %0d want 0", pulses); end
      start_edge(14'd1023);
      wait_a(20, n);
      total++; if (n !== 11) begin bad++; $display("FAIL abort_relat: got %0d want 11", n); end
      total++; if (ifa.hex !== EXP_1023) begin bad++; $display("FAIL abort_rehex: got %h want %h", ifa.hex, EXP_1023); end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      value = '0;
      test_reset;
      test_1023;
      test_blank;
      test_zero;
      test_back_to_back;
      test_overflow;
      test_reset_abort;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
